branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the pipelined CPU's fetch stage.
- Replaces the fixed predict-not-taken / flush-on-EX-resolve scheme with a table of 2-bit saturating counters.
- Each entry is indexed by PC and has a tag check. The table is trained by branch outcomes resolved in EX.
- A sequential init sweep clears the table after reset, so the arrays need no per-entry reset and map to RAM.

---
 rtl/branch_predictor_if.sv | 45 ++++
 rtl/branch_predictor.sv | 234 +++++++++++++++++++++++
 tb/tb_branch_predictor.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/EX side bundle of the dynamic branch predictor
// Signals (direction seen from the predictor, i.e. the slave modport):
//   ready             out  table initialised and accepting traffic
//   lookup_valid/pc   in   fetch PC presented this cycle
//   pred_valid        out  registered lookup_valid & ready
//   pred_hit/taken    out  tag-hit and predicted direction
//   pred_target       out  predicted target (0 when target storage is absent)
//   update_*          in   branch outcome resolved in EX
//   stat_updates      out  accepted update count (wraps)
//   stat_mispredicts  out  accepted updates flagged as mispredicted (wraps)
interface branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             ready;
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_valid;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic             update_taken;
  logic [PC_W-1:0]  update_target;
  logic             update_mispredict;
  logic [CNT_W-1:0] stat_updates;
  logic [CNT_W-1:0] stat_mispredicts;

  // CPU pipeline side
  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_taken, update_target, update_mispredict,
    input  ready, pred_valid, pred_hit, pred_taken, pred_target,
    input  stat_updates, stat_mispredicts
  );

  // Predictor side
  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_taken, update_target, update_mispredict,
    output ready, pred_valid, pred_hit, pred_taken, pred_target,
    output stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tagged 2-bit saturating counter branch predictor
// Optional feature macro: BRANCH_TARGET_EN (per-entry target storage).
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bp   branch_predictor_if.slave: lookup, prediction, update and statistics
// After reset an init sweep clears one entry per cycle; the table arrays
// carry no reset so they can map onto RAM.
module branch_predictor #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 2 ** IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  // ---------------------------------------------------------------------
  // Table storage (no reset)
  // ---------------------------------------------------------------------
  logic             valid_mem [ENTRIES];
  logic [TAG_W-1:0] tag_mem   [ENTRIES];
  logic [1:0]       ctr_mem   [ENTRIES];
`ifdef BRANCH_TARGET_EN
  logic [PC_W-1:0]  target_mem[ENTRIES];
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]       state_q,           state_d;
  logic [IDX_W-1:0] init_ptr_q,        init_ptr_d;
  logic             pred_valid_q,      pred_valid_d;
  logic             pred_hit_q,        pred_hit_d;
  logic             pred_taken_q,      pred_taken_d;
  logic [CNT_W-1:0] stat_updates_q,    stat_updates_d;
  logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;
`ifdef BRANCH_TARGET_EN
  logic [PC_W-1:0]  pred_target_q,     pred_target_d;
`endif

  // ---------------------------------------------------------------------
  // Address decode: word-aligned index, tag directly above it
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign lk_tag = bp.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = bp.update_pc[IDX_W+1:2];
  assign up_tag = bp.update_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Bits outside index/tag (and the byte offset) do not affect the table.
  logic unused_bits;
`ifdef BRANCH_TARGET_EN
  assign unused_bits = ^{bp.lookup_pc, bp.update_pc};
`else
  assign unused_bits = ^{bp.lookup_pc, bp.update_pc, bp.update_target};
`endif

  // Combinational reads see the table as it was before this cycle's write,
  // which gives read-before-write on a same-index lookup/update pair.
  logic       lk_hit, up_hit;
  logic [1:0] lk_ctr, up_ctr;

  assign lk_ctr = ctr_mem[lk_idx];
  assign up_ctr = ctr_mem[up_idx];
  assign lk_hit = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign up_hit = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);

  logic run;
  logic lk_accept;
  logic up_accept;

  assign run       = (state_q == ST_RUN);
  assign lk_accept = bp.lookup_valid && run;
  assign up_accept = bp.update_valid && run;

  // ---------------------------------------------------------------------
  // Table write port: init sweep in INIT, training in RUN
  // ---------------------------------------------------------------------
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_ctr;
`ifdef BRANCH_TARGET_EN
  logic             wr_tgt_en;
`endif

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = init_ptr_q;
    wr_valid = 1'b0;
    wr_tag   = '0;
    wr_ctr   = CTR_INIT;
`ifdef BRANCH_TARGET_EN
    wr_tgt_en = 1'b0;
`endif
    if (!run) begin
      wr_en = 1'b1;
    end else if (up_accept) begin
      wr_en    = 1'b1;
      wr_idx   = up_idx;
      wr_valid = 1'b1;
      wr_tag   = up_tag;
      if (up_hit) begin
        // Saturating train: 11 holds on taken, 00 holds on not-taken.
        if (bp.update_taken) begin
          wr_ctr = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
        end else begin
          wr_ctr = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
        end
`ifdef BRANCH_TARGET_EN
        wr_tgt_en = bp.update_taken;
`endif
      end else begin
        // Allocate with a weak counter in the resolved direction.
        wr_ctr = bp.update_taken ? 2'b10 : 2'b01;
`ifdef BRANCH_TARGET_EN
        wr_tgt_en = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_mem[wr_idx] <= wr_valid;
      tag_mem[wr_idx]   <= wr_tag;
      ctr_mem[wr_idx]   <= wr_ctr;
    end
  end

`ifdef BRANCH_TARGET_EN
  always_ff @(posedge clk) begin
    if (wr_tgt_en) begin
      target_mem[wr_idx] <= bp.update_target;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d            = state_q;
    init_ptr_d         = init_ptr_q;
    pred_valid_d       = lk_accept;
    pred_hit_d         = pred_hit_q;
    pred_taken_d       = pred_taken_q;
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
`ifdef BRANCH_TARGET_EN
    pred_target_d      = pred_target_q;
`endif

    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      // The edge that clears the last entry also enters RUN.
      if (init_ptr_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end

    // Prediction outputs hold between accepted lookups.
    if (lk_accept) begin
      pred_hit_d   = lk_hit;
      pred_taken_d = lk_hit && lk_ctr[1];
`ifdef BRANCH_TARGET_EN
      pred_target_d = lk_hit ? target_mem[lk_idx] : '0;
`endif
    end

    if (up_accept) begin
      stat_updates_d = stat_updates_q + 1'b1;
      if (bp.update_mispredict) begin
        stat_mispredicts_d = stat_mispredicts_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_INIT;
      init_ptr_q         <= '0;
      pred_valid_q       <= 1'b0;
      pred_hit_q         <= 1'b0;
      pred_taken_q       <= 1'b0;
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
`ifdef BRANCH_TARGET_EN
      pred_target_q      <= '0;
`endif
    end else begin
      state_q            <= state_d;
      init_ptr_q         <= init_ptr_d;
      pred_valid_q       <= pred_valid_d;
      pred_hit_q         <= pred_hit_d;
      pred_taken_q       <= pred_taken_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
`ifdef BRANCH_TARGET_EN
      pred_target_q      <= pred_target_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bp.ready            = run;
  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_hit         = pred_hit_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.stat_updates     = stat_updates_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
`ifdef BRANCH_TARGET_EN
  assign bp.pred_target      = pred_target_q;
`else
  assign bp.pred_target      = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed bench for branch_predictor
module tb_branch_predictor;

  localparam int PC_W    = 32;
  localparam int CNT_W   = 16;
  localparam int ENTRIES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bp_if ();

  branch_predictor #(
    .PC_W(PC_W), .IDX_W(6), .TAG_W(8), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-entry valid/tag/counter/target as plain integers.
  bit          m_valid[ENTRIES];
  int          m_tag  [ENTRIES];
  int          m_ctr  [ENTRIES];
  logic [31:0] m_tgt  [ENTRIES];
  bit          m_ready;
  int          m_upd;
  int          m_mis;
  bit          exp_pv;
  bit          exp_hit;
  bit          exp_taken;
  logic [31:0] exp_tgt;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_ready   = 1'b0;
    m_upd     = 0;
    m_mis     = 0;
    exp_pv    = 1'b0;
    exp_hit   = 1'b0;
    exp_taken = 1'b0;
    exp_tgt   = '0;
  endtask

  task automatic idle_inputs();
    bp_if.lookup_valid      = 1'b0;
    bp_if.lookup_pc         = '0;
    bp_if.update_valid      = 1'b0;
    bp_if.update_pc         = '0;
    bp_if.update_taken      = 1'b0;
    bp_if.update_target     = '0;
    bp_if.update_mispredict = 1'b0;
  endtask

  task automatic check_outputs(string tag);
    logic [31:0] tgt_exp;
`ifdef BRANCH_TARGET_EN
    tgt_exp = exp_tgt;
`else
    tgt_exp = '0;
`endif
    chk({tag, ".ready"},      64'(bp_if.ready),            64'(m_ready));
    chk({tag, ".pred_valid"}, 64'(bp_if.pred_valid),       64'(exp_pv));
    chk({tag, ".pred_hit"},   64'(bp_if.pred_hit),         64'(exp_hit));
    chk({tag, ".pred_taken"}, 64'(bp_if.pred_taken),       64'(exp_taken));
    chk({tag, ".pred_tgt"},   64'(bp_if.pred_target),      64'(tgt_exp));
    chk({tag, ".stat_upd"},   64'(bp_if.stat_updates),     64'(m_upd));
    chk({tag, ".stat_mis"},   64'(bp_if.stat_mispredicts), 64'(m_mis));
  endtask

  // One cycle of traffic, entered and left at posedge+1.
  task automatic do_op(string tag, bit lv, logic [31:0] lpc,
                       bit uv, logic [31:0] upc, bit ut,
                       logic [31:0] utgt, bit um);
    int i;
    int j;
    bp_if.lookup_valid      = lv;
    bp_if.lookup_pc         = lpc;
    bp_if.update_valid      = uv;
    bp_if.update_pc         = upc;
    bp_if.update_taken      = ut;
    bp_if.update_target     = utgt;
    bp_if.update_mispredict = um;

    // Prediction reflects the table before this cycle's update.
    exp_pv = lv && m_ready;
    if (exp_pv) begin
      i         = idx_of(lpc);
      exp_hit   = m_valid[i] && (m_tag[i] == tag_of(lpc));
      exp_taken = exp_hit && (m_ctr[i] >= 2);
      exp_tgt   = exp_hit ? m_tgt[i] : 32'h0;
    end
    if (uv && m_ready) begin
      j = idx_of(upc);
      if (m_valid[j] && m_tag[j] == tag_of(upc)) begin
        m_ctr[j] = ut ? ((m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1)
                      : ((m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1);
        if (ut) m_tgt[j] = utgt;
      end else begin
        m_valid[j] = 1'b1;
        m_tag[j]   = tag_of(upc);
        m_ctr[j]   = ut ? 2 : 1;
        m_tgt[j]   = utgt;
      end
      m_upd = (m_upd + 1) % (1 << CNT_W);
      if (um) m_mis = (m_mis + 1) % (1 << CNT_W);
    end

    @(posedge clk);
    #1;
    idle_inputs();
    check_outputs(tag);
  endtask

  task automatic lookup(string tag, logic [31:0] pc);
    do_op(tag, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic update(string tag, logic [31:0] pc, bit t, logic [31:0] tgt, bit mis);
    do_op(tag, 1'b0, 32'h0, 1'b1, pc, t, tgt, mis);
  endtask

  // Assert reset (asynchronously), check reset state, release and sweep.
  task automatic do_reset_init();
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bp_if.lookup_valid = 1'b1;
    bp_if.lookup_pc    = 32'h0000_0040;
    // Updates during the sweep must be dropped.
    bp_if.update_valid      = 1'b1;
    bp_if.update_pc         = 32'h0000_0040;
    bp_if.update_taken      = 1'b1;
    bp_if.update_mispredict = 1'b1;
    for (int k = 0; k < ENTRIES; k++) begin
      chk("init.ready", 64'(bp_if.ready), 64'(0));
      chk("init.pred_valid", 64'(bp_if.pred_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk("init.ready_up", 64'(bp_if.ready), 64'(1));
    chk("init.pred_valid_last", 64'(bp_if.pred_valid), 64'(0));
    chk("init.stat_upd", 64'(bp_if.stat_updates), 64'(0));
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lpc;
    logic [31:0] upc;

    idle_inputs();
    rst = 1'b1;
    #1;

    // ---- Reset and init sweep ----
    do_reset_init();
    lookup("first_lookup", 32'h0000_0040);
    chk("first_lookup.miss", 64'(bp_if.pred_hit), 64'(0));

    // ---- Allocate then hit ----
    update("alloc", 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    lookup("alloc_hit", 32'h0000_0040);
    chk("alloc_hit.hit", 64'(bp_if.pred_hit), 64'(1));
    chk("alloc_hit.taken", 64'(bp_if.pred_taken), 64'(1));
    // Outputs hold while no lookup is presented.
    do_op("hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("hold.hit", 64'(bp_if.pred_hit), 64'(1));

    // ---- Saturation ----
    for (int k = 0; k < 4; k++) update("sat_up", 32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
    update("sat_dn1", 32'h0000_0040, 1'b0, 32'h0, 1'b0);
    lookup("sat_l1", 32'h0000_0040);
    chk("sat_l1.taken", 64'(bp_if.pred_taken), 64'(1));
    update("sat_dn2", 32'h0000_0040, 1'b0, 32'h0, 1'b0);
    lookup("sat_l2", 32'h0000_0040);
    chk("sat_l2.taken", 64'(bp_if.pred_taken), 64'(0));
    chk("sat_l2.hit", 64'(bp_if.pred_hit), 64'(1));

    // ---- Alias / tag ----
    update("alias_alloc", 32'h0000_0040, 1'b1, 32'h0000_0300, 1'b0);
    lookup("alias_look", 32'h0000_0140);
    chk("alias_look.hit", 64'(bp_if.pred_hit), 64'(0));
    chk("alias_look.taken", 64'(bp_if.pred_taken), 64'(0));
    update("alias_realloc", 32'h0000_0140, 1'b0, 32'h0000_0400, 1'b0);
    lookup("alias_orig", 32'h0000_0040);
    chk("alias_orig.hit", 64'(bp_if.pred_hit), 64'(0));
    lookup("alias_new", 32'h0000_0143);
    chk("alias_new.hit", 64'(bp_if.pred_hit), 64'(1));

    // ---- Read-before-write ----
    do_op("rbw_same", 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0500, 1'b0);
    chk("rbw_same.hit", 64'(bp_if.pred_hit), 64'(0));
    lookup("rbw_next", 32'h0000_0080);
    chk("rbw_next.hit", 64'(bp_if.pred_hit), 64'(1));
    chk("rbw_next.taken", 64'(bp_if.pred_taken), 64'(1));

    // ---- Randomized traffic over a small PC pool to force hits/aliases ----
    for (int n = 0; n < 600; n++) begin
      lpc = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8) |
            (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) upc = lpc;
      else upc = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 8) |
                 (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      do_op("rand", 1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    // ---- Stats from a clean reset, then reset mid-run ----
    do_reset_init();
    update("st1", 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b1);
    update("st2", 32'h0000_0080, 1'b0, 32'h0000_0200, 1'b1);
    update("st3", 32'h0000_00C0, 1'b1, 32'h0000_0300, 1'b0);
    chk("stats.updates", 64'(bp_if.stat_updates), 64'(3));
    chk("stats.mispredicts", 64'(bp_if.stat_mispredicts), 64'(2));
    lookup("pre_rst", 32'h0000_0040);
    chk("pre_rst.hit", 64'(bp_if.pred_hit), 64'(1));
    do_reset_init();
    lookup("post_rst", 32'h0000_0040);
    chk("post_rst.hit", 64'(bp_if.pred_hit), 64'(0));
    chk("post_rst.pred_valid", 64'(bp_if.pred_valid), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
